// File: rtl/ball_pkg.sv
// Shared types and constants for the double-buffered ball parameter table.
package ball_pkg;

    localparam int NUM_BALLS = 4;
    localparam int FIELDS    = 4;
    localparam int N_ENTRIES = NUM_BALLS * FIELDS;

    // Word position of each parameter inside one ball's record
    typedef enum logic [1:0] {
        F_RADIUS = 2'd0,
        F_POSX   = 2'd1,
        F_POSY   = 2'd2,
        F_POSZ   = 2'd3
    } field_t;

    // Commit sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COPY    = 2'd2,
        DONE_ST = 2'd3
    } commit_state_t;

    // CTRL write bits
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    // STATUS read bits
    localparam int ST_PENDING_BIT  = 0;
    localparam int ST_BUSY_BIT     = 1;
    localparam int ST_DONE_BIT     = 2;
    localparam int ST_OVERRUN_BIT  = 3;
    localparam int ST_IRQ_EN_BIT   = 4;

    // Flat table index of one ball parameter
    function automatic int entry_index(input int ball, input field_t field);
        return ball * FIELDS + int'(field);
    endfunction

endpackage

// File: rtl/ball_table_commit_vs_edge_sync.sv
// Brings the asynchronous active-low vsync into the CLK domain and emits a
// one-cycle pulse on its falling edge. All flops idle high so a vsync that is
// already high after reset does not produce a spurious pulse.
module vs_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic async_in,
    output logic fall_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Two-stage synchroniser followed by a history flop for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Falling edge: previous synchronised sample high, current one low
    assign fall_pulse = prev_r & ~sync2_r;

endmodule

// File: rtl/ball_table_commit.sv
// Double-buffered ball parameter table. Software fills the staging bank over
// Avalon-MM and requests a commit; the staging bank is copied into the active
// bank one word per cycle starting at the next vsync, so the renderers always
// see a complete frame's worth of parameters.
module ball_table_commit #(
    parameter int NUM_BALLS = ball_pkg::NUM_BALLS,
    parameter int FIELDS    = ball_pkg::FIELDS,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            AVL_CS,
    input  logic                            AVL_READ,
    input  logic                            AVL_WRITE,
    input  logic [3:0]                      AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]               AVL_ADDR,
    input  logic [DATA_W-1:0]               AVL_WRITEDATA,
    output logic [DATA_W-1:0]               AVL_READDATA,
    output logic                            AVL_WAITREQ,
    input  logic                            VGA_VS,
    output logic [NUM_BALLS*FIELDS*DATA_W-1:0] ACTIVE_TABLE,
    output logic                            IRQ
);

    import ball_pkg::*;

    localparam int N     = NUM_BALLS * FIELDS;
    localparam int IDX_W = $clog2(N);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] staging_r [N];
    logic [DATA_W-1:0] active_r  [N];

    commit_state_t     state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              rearm_r;
    logic              done_r;
    logic              overrun_r;
    logic              irq_en_r;
    logic [31:0]       frame_cnt_r;

    logic              vs_start_s;
    logic              addr_stage_s;
    logic              addr_ctrl_s;
    logic              addr_frame_s;
    logic              stage_req_s;
    logic              stage_wr_s;
    logic              ctrl_wr_s;
    logic              commit_s;
    logic              clear_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [31:0]       status_s;
    logic [DATA_W-1:0] rdata_s;

    vs_edge_sync u_vs_sync (
        .CLK        (CLK),
        .RESET      (RESET),
        .async_in   (VGA_VS),
        .fall_pulse (vs_start_s)
    );

    // Address decode and write qualification
    assign addr_stage_s = (AVL_ADDR < ADDR_W'(N));
    assign addr_ctrl_s  = (AVL_ADDR == ADDR_W'(N));
    assign addr_frame_s = (AVL_ADDR == ADDR_W'(N + 1));
    assign wr_idx_s     = AVL_ADDR[IDX_W-1:0];

    assign stage_req_s  = AVL_CS & AVL_WRITE & addr_stage_s;
    assign stage_wr_s   = stage_req_s & (state_r != COPY);
    assign ctrl_wr_s    = AVL_CS & AVL_WRITE & addr_ctrl_s;
    assign commit_s     = ctrl_wr_s & AVL_BYTE_EN[0] & AVL_WRITEDATA[CTRL_COMMIT_BIT];
    assign clear_s      = ctrl_wr_s & AVL_BYTE_EN[0] & AVL_WRITEDATA[CTRL_CLEAR_BIT];

    // Only staging writes stall, and only while the copy is reading staging
    assign AVL_WAITREQ  = stage_req_s & (state_r == COPY);

    assign IRQ          = done_r & irq_en_r;

    // Staging bank: byte-lane writes from software, stalled during COPY
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                staging_r[i] <= '0;
            end
        end else if (stage_wr_s) begin
            for (int b = 0; b < NB; b++) begin
                if (AVL_BYTE_EN[b]) begin
                    staging_r[wr_idx_s][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
                end
            end
        end
    end

    // Active bank: one entry copied from staging per COPY cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                active_r[i] <= '0;
            end
        end else if (state_r == COPY) begin
            active_r[idx_r] <= staging_r[idx_r];
        end
    end

    // Commit sequencer: waits for vsync, walks the table, then rearms or idles
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            idx_r   <= '0;
            rearm_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A vsync in the same cycle as the commit is too late for this frame
                    if (commit_s) begin
                        state_r <= ARMED;
                    end
                end
                ARMED: begin
                    if (vs_start_s) begin
                        state_r <= COPY;
                        idx_r   <= '0;
                    end
                end
                COPY: begin
                    if (commit_s) begin
                        rearm_r <= 1'b1;
                    end
                    if (idx_r == IDX_W'(N - 1)) begin
                        state_r <= DONE_ST;
                        idx_r   <= '0;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                DONE_ST: begin
                    idx_r   <= '0;
                    rearm_r <= 1'b0;
                    if (rearm_r || commit_s) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    rearm_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags; setting takes priority over a software clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (state_r == DONE_ST) begin
                done_r <= 1'b1;
            end else if (clear_s) begin
                done_r <= 1'b0;
            end
            if ((state_r == COPY) && vs_start_s) begin
                overrun_r <= 1'b1;
            end else if (clear_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Interrupt enable, written whenever byte lane 0 of CTRL is written
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s && AVL_BYTE_EN[0]) begin
            irq_en_r <= AVL_WRITEDATA[CTRL_IRQ_EN_BIT];
        end
    end

    // Frame counter advances on every vsync regardless of commit activity
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt_r <= 32'd0;
        end else if (vs_start_s) begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                 = 32'd0;
        status_s[ST_PENDING_BIT] = (state_r == ARMED) | rearm_r;
        status_s[ST_BUSY_BIT]    = (state_r == COPY);
        status_s[ST_DONE_BIT]    = done_r;
        status_s[ST_OVERRUN_BIT] = overrun_r;
        status_s[ST_IRQ_EN_BIT]  = irq_en_r;
        status_s[31:16]          = frame_cnt_r[15:0];
    end

    // Read mux: staging (not active) contents, STATUS, FRAME_CNT, else zero
    always_comb begin
        rdata_s = '0;
        if (AVL_CS && AVL_READ) begin
            if (addr_stage_s) begin
                rdata_s = staging_r[wr_idx_s];
            end else if (addr_ctrl_s) begin
                rdata_s = DATA_W'(status_s);
            end else if (addr_frame_s) begin
                rdata_s = DATA_W'(frame_cnt_r);
            end else begin
                rdata_s = '0;
            end
        end else begin
            rdata_s = '0;
        end
    end

    assign AVL_READDATA = rdata_s;

    // Flatten the active bank for the renderers
    for (genvar k = 0; k < N; k++) begin : g_active
        assign ACTIVE_TABLE[k*DATA_W +: DATA_W] = active_r[k];
    end

endmodule
